gpu_wb_cmd_bridge: RTL and testbench

- Wishbone slave front-end sitting directly upstream of gpu_core inside gpu.
- Turns 32-bit Wishbone register accesses into gpu_core command transactions: 32-bit command, 64-bit data_in, stb/ack handshake.
- Captures the 64-bit data_out of DATA_READ commands into readback registers.
- Tracks issue status and a command counter for software polling.

---
 rtl/gpu_wb_cmd_bridge_if.sv | 29 ++
 rtl/gpu_wb_cmd_bridge.sv | 111 +++++++++++
 tb/tb_gpu_wb_cmd_bridge.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_wb_cmd_bridge_if.sv
// Bus bundle between the Wishbone host, the command bridge and gpu_core.
// Signal names follow the Wishbone slave / gpu_core port names.
interface gpu_wb_cmd_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] core_command;
  logic [63:0] core_data_in;
  logic [63:0] core_data_out;
  logic        core_stb;
  logic        core_ack;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  core_data_out, core_ack,
    output wbs_ack_o, wbs_dat_o, core_command, core_data_in, core_stb
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output core_data_out, core_ack,
    input  wbs_ack_o, wbs_dat_o, core_command, core_data_in, core_stb
  );
endinterface

// File: rtl/gpu_wb_cmd_bridge.sv
// Wishbone slave that turns register writes into gpu_core command transactions
// and captures DATA_READ results for software readback.
module gpu_wb_cmd_bridge #(
  parameter int unsigned OP_LSB       = 12,
  parameter logic [3:0]  OP_DATA_READ = 4'b0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  gpu_wb_cmd_bridge_if.slave       bus
);

  localparam logic [2:0] AdrDataLo  = 3'd0;
  localparam logic [2:0] AdrDataHi  = 3'd1;
  localparam logic [2:0] AdrCmd     = 3'd2;
  localparam logic [2:0] AdrStatus  = 3'd3;
  localparam logic [2:0] AdrRdataLo = 3'd4;
  localparam logic [2:0] AdrRdataHi = 3'd5;

  logic        r_ack;
  logic [31:0] r_dat;
  logic [31:0] r_cmd;
  logic [31:0] r_data_lo;
  logic [31:0] r_data_hi;
  logic [63:0] r_rdata;
  logic        r_pending;
  logic        r_rvalid;
  logic [15:0] r_count;

  logic [2:0]  w_addr;
  logic        w_req;
  logic        w_stall;
  logic        w_accept;
  logic        w_cmd_issue;
  logic        w_core_done;
  logic [31:0] w_rdata;
  logic        w_unused_adr;

  assign w_unused_adr = ^{bus.wbs_adr_i[31:5], bus.wbs_adr_i[1:0]};

  always_comb begin
    w_addr  = bus.wbs_adr_i[4:2];
    w_req   = bus.wbs_cyc_i & bus.wbs_stb_i & ~r_ack;
    // DATA_*/CMD writes and RDATA reads wait out an in-flight command.
    w_stall = r_pending &
              ((bus.wbs_we_i & (w_addr == AdrDataLo || w_addr == AdrDataHi || w_addr == AdrCmd)) |
               (~bus.wbs_we_i & (w_addr == AdrRdataLo || w_addr == AdrRdataHi)));
    w_accept    = w_req & ~w_stall;
    w_cmd_issue = w_accept & bus.wbs_we_i & (w_addr == AdrCmd) & (bus.wbs_sel_i == 4'hF);
    w_core_done = r_pending & bus.core_ack;

    w_rdata = '0;
    unique case (w_addr)
      AdrDataLo:  w_rdata = r_data_lo;
      AdrDataHi:  w_rdata = r_data_hi;
      AdrCmd:     w_rdata = r_cmd;
      AdrStatus:  w_rdata = {r_count, 14'd0, r_rvalid, r_pending};
      AdrRdataLo: w_rdata = r_rdata[31:0];
      AdrRdataHi: w_rdata = r_rdata[63:32];
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_cmd     <= '0;
      r_data_lo <= '0;
      r_data_hi <= '0;
      r_rdata   <= '0;
      r_pending <= 1'b0;
      r_rvalid  <= 1'b0;
      r_count   <= '0;
    end else begin
      r_ack <= w_accept;
      r_dat <= (w_accept & ~bus.wbs_we_i) ? w_rdata : '0;

      if (w_accept & bus.wbs_we_i & (w_addr == AdrDataLo)) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.wbs_sel_i[i]) r_data_lo[i*8 +: 8] <= bus.wbs_dat_i[i*8 +: 8];
        end
      end
      if (w_accept & bus.wbs_we_i & (w_addr == AdrDataHi)) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.wbs_sel_i[i]) r_data_hi[i*8 +: 8] <= bus.wbs_dat_i[i*8 +: 8];
        end
      end

      // Issue and completion are exclusive: issue needs pending low, completion needs it high.
      if (w_cmd_issue) begin
        r_cmd     <= bus.wbs_dat_i;
        r_pending <= 1'b1;
        r_rvalid  <= 1'b0;
      end else if (w_core_done) begin
        r_pending <= 1'b0;
        r_count   <= r_count + 16'd1;
        if (r_cmd[OP_LSB +: 4] == OP_DATA_READ) begin
          r_rdata  <= bus.core_data_out;
          r_rvalid <= 1'b1;
        end
      end
    end
  end

  assign bus.wbs_ack_o    = r_ack;
  assign bus.wbs_dat_o    = r_dat;
  assign bus.core_command = r_cmd;
  assign bus.core_data_in = {r_data_hi, r_data_lo};
  assign bus.core_stb     = r_pending;

endmodule

// File: tb/tb_gpu_wb_cmd_bridge.sv
// Self-checking bench for gpu_wb_cmd_bridge: directed register-map scenarios plus
// randomized traffic checked every cycle against a register-level model.
module tb_gpu_wb_cmd_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpu_wb_cmd_bridge_if bus_if ();

  gpu_wb_cmd_bridge #(
    .OP_LSB       (12),
    .OP_DATA_READ (4'b0000)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus_if.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference model: register file state as software sees it.
  logic        m_ack, m_pending, m_rvalid;
  logic [31:0] m_dato, m_cmd;
  logic [63:0] m_data, m_rdata;
  logic [15:0] m_count;

  logic [2:0]  ma;
  logic        mok;
  logic [31:0] mrd;
  logic [63:0] mnd;

  always_comb begin
    ma  = bus_if.wbs_adr_i[4:2];
    mok = bus_if.wbs_cyc_i && bus_if.wbs_stb_i && !m_ack;
    if (m_pending && (bus_if.wbs_we_i ? (ma <= 3'd2) : (ma == 3'd4 || ma == 3'd5))) mok = 1'b0;
    mrd = '0;
    if (mok && !bus_if.wbs_we_i) begin
      case (ma)
        3'd0: mrd = m_data[31:0];
        3'd1: mrd = m_data[63:32];
        3'd2: mrd = m_cmd;
        3'd3: mrd = {m_count, 14'd0, m_rvalid, m_pending};
        3'd4: mrd = m_rdata[31:0];
        3'd5: mrd = m_rdata[63:32];
        default: mrd = '0;
      endcase
    end
    mnd = m_data;
    if (mok && bus_if.wbs_we_i && ma <= 3'd1) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_if.wbs_sel_i[b]) mnd[int'(ma[0])*32 + b*8 +: 8] = bus_if.wbs_dat_i[b*8 +: 8];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ack <= 0; m_dato <= 0; m_pending <= 0; m_rvalid <= 0;
      m_cmd <= 0; m_data <= 0; m_rdata <= 0; m_count <= 0;
    end else begin
      m_ack  <= mok;
      m_dato <= mrd;
      m_data <= mnd;
      if (mok && bus_if.wbs_we_i && ma == 3'd2 && bus_if.wbs_sel_i == 4'hF) begin
        m_cmd <= bus_if.wbs_dat_i; m_pending <= 1; m_rvalid <= 0;
      end else if (m_pending && bus_if.core_ack) begin
        m_pending <= 0;
        m_count   <= m_count + 16'd1;
        if (m_cmd[15:12] == 4'd0) begin
          m_rdata <= bus_if.core_data_out; m_rvalid <= 1;
        end
      end
    end
  end

  // Core responder: acks core_stb after a programmable or random delay.
  int          rsp_delay = 0;
  bit          rsp_rand  = 0;
  logic [63:0] rsp_data  = '0;
  int          spur_cnt  = 0;
  int          spur_done = 0;
  int          cd        = -1;
  int          ack_edge  = 0;

  initial begin
    bus_if.core_ack      = 1'b0;
    bus_if.core_data_out = '0;
    forever begin
      @(negedge clk);
      bus_if.core_ack      = 1'b0;
      bus_if.core_data_out = {$urandom, $urandom};
      if (rst) begin
        cd = -1;
      end else if (spur_cnt != spur_done) begin
        bus_if.core_ack = 1'b1;
        spur_done++;
      end else if (bus_if.core_stb) begin
        if (cd < 0) cd = rsp_rand ? int'($urandom_range(0, 4)) : rsp_delay;
        if (cd == 0) begin
          bus_if.core_ack = 1'b1;
          if (!rsp_rand) bus_if.core_data_out = rsp_data;
          ack_edge = cyc_n + 1;
          cd = -1;
        end else begin
          cd--;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output int edge_n);
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_stb_i = 1'b1;
    bus_if.wbs_we_i  = we;
    bus_if.wbs_adr_i = adr;
    bus_if.wbs_dat_i = dat;
    bus_if.wbs_sel_i = sel;
    rdat   = '0;
    edge_n = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.wbs_ack_o) begin
        rdat   = bus_if.wbs_dat_o;
        edge_n = cyc_n;
        break;
      end
    end
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    if (edge_n < 0) chk("wb_ack_timeout", 64'(adr), 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    int e;
    wb_xfer(1'b1, adr, dat, sel, d, e);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    int e;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, d, e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_if.core_stb && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.core_stb) chk("core_idle_timeout", 64'(bus_if.core_stb), 64'd0);
  endtask

  logic [31:0] d;
  int          e2;

  initial begin
    rst = 1'b1;
    bus_if.wbs_cyc_i = 0; bus_if.wbs_stb_i = 0; bus_if.wbs_we_i = 0;
    bus_if.wbs_sel_i = 0; bus_if.wbs_adr_i = 0; bus_if.wbs_dat_i = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge clk);
        chk("cyc_ack",     64'(bus_if.wbs_ack_o),    64'(m_ack));
        chk("cyc_dat_o",   64'(bus_if.wbs_dat_o),    64'(m_dato));
        chk("cyc_stb",     64'(bus_if.core_stb),     64'(m_pending));
        chk("cyc_command", 64'(bus_if.core_command), 64'(m_cmd));
        chk("cyc_data_in", bus_if.core_data_in,      m_data);
      end
    join_none

    rd(32'h0C, d); chk("reset_status", 64'(d), 64'h0);

    // Basic issue.
    rsp_delay = 2;
    wr(32'h00, 32'h0000_1000, 4'hF);
    wr(32'h04, 32'h2000_3000, 4'hF);
    wr(32'h08, 32'h0000_1000, 4'hF);
    chk("issue_stb", 64'(bus_if.core_stb), 64'd1);
    chk("issue_data_in", bus_if.core_data_in, 64'h2000_3000_0000_1000);
    chk("issue_command", 64'(bus_if.core_command), 64'h0000_1000);
    wait_idle();
    rd(32'h0C, d); chk("status_after_issue", 64'(d), 64'h0001_0000);

    // DATA_READ capture.
    rsp_delay = 0;
    rsp_data  = 64'hDEAD_BEEF_CAFE_F00D;
    wr(32'h08, 32'h0000_0000, 4'hF);
    rd(32'h10, d); chk("rdata_lo", 64'(d), 64'hCAFE_F00D);
    rd(32'h14, d); chk("rdata_hi", 64'(d), 64'hDEAD_BEEF);
    rd(32'h0C, d); chk("status_rvalid", 64'(d), 64'h0002_0002);

    // Back-to-back CMD stalls until the first core ack.
    rsp_delay = 6;
    wr(32'h08, 32'h0000_2000, 4'hF);
    wb_xfer(1'b1, 32'h08, 32'h0000_3000, 4'hF, d, e2);
    chk("second_cmd_ack_edge", 64'(e2), 64'(ack_edge + 1));
    wait_idle();
    rd(32'h0C, d); chk("status_two_issues", 64'(d), 64'h0004_0000);

    // Byte lanes and partial CMD write.
    wr(32'h00, 32'h1111_1111, 4'hF);
    wr(32'h00, 32'h0000_AB00, 4'b0010);
    rd(32'h00, d); chk("data_lo_bytes", 64'(d), 64'h1111_AB11);
    wr(32'h08, 32'hFFFF_FFFF, 4'h3);
    repeat (2) @(negedge clk);
    chk("partial_cmd_no_stb", 64'(bus_if.core_stb), 64'd0);
    rd(32'h08, d); chk("partial_cmd_ignored", 64'(d), 64'h0000_3000);

    // Spurious ack, unmapped space.
    spur_cnt++;
    repeat (3) @(negedge clk);
    rd(32'h0C, d); chk("spurious_status", 64'(d), 64'h0004_0000);
    rd(32'h10, d); chk("spurious_rdata", 64'(d), 64'hCAFE_F00D);
    wr(32'h18, 32'h5555_5555, 4'hF);
    rd(32'h1C, d); chk("unmapped_read", 64'(d), 64'h0);

    // Randomized traffic.
    rsp_rand = 1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] adr, dat;
      logic [3:0]  sel;
      logic        we;
      adr = $urandom;
      dat = $urandom;
      we  = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 1) == 0) dat[15:12] = 4'd0;
      if ($urandom_range(0, 15) == 0) spur_cnt++;
      wb_xfer(we, adr, dat, sel, d, e2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of a command.
    rsp_rand  = 0;
    rsp_delay = 10;
    wr(32'h00, 32'h1234_5678, 4'hF);
    wr(32'h08, 32'h0000_0000, 4'hF);
    @(negedge clk);
    chk("pre_reset_stb", 64'(bus_if.core_stb), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ack",     64'(bus_if.wbs_ack_o),    64'd0);
    chk("rst_dat_o",   64'(bus_if.wbs_dat_o),    64'd0);
    chk("rst_stb",     64'(bus_if.core_stb),     64'd0);
    chk("rst_command", 64'(bus_if.core_command), 64'd0);
    chk("rst_data_in", bus_if.core_data_in,      64'd0);
    spur_cnt++;
    repeat (3) @(negedge clk);
    rd(32'h0C, d); chk("post_reset_status", 64'(d), 64'h0);
    rd(32'h10, d); chk("post_reset_rdata", 64'(d), 64'h0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
